// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl
//    Scan-code controller between the ps2_keyboard receiver FIFO and the
//    board consumers. It pops one byte at a time from the receiver, folds the
//    Set-2 prefixes (E0 extended, F0 break) into the final code byte, and
//    reports one-cycle key events together with the currently held key, a
//    press counter that ignores typematic repeats, and a sticky overflow flag.
//
// Ports
//    clk          system clock, shared with ps2_keyboard
//    clrn         asynchronous active-low reset
//    en           allow a new pop (sampled only while idle)
//    ready        receiver FIFO non-empty, data valid
//    data         byte at the head of the receiver FIFO
//    overflow     receiver FIFO overflow indication
//    nextdata_n   registered active-low pop strobe to the receiver
//    key_event    one-cycle pulse per completed make/break code
//    key_break    last event was a release
//    key_ext      last event carried an E0 prefix
//    key_code     final code byte of the last event
//    key_down     a key is currently held
//    held_code    code of the held key
//    held_ext     extended flag of the held key
//    press_count  new presses, wraps modulo 2^CNT_W
//    ovf_flag     sticky copy of overflow
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for en && ready; latches data and drops nextdata_n
// POP    | nextdata_n low for this cycle; byte_q decoded at its end
// SETTLE | receiver updates ready/data after the pop; event visible here

module ps2_key_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             en,
   input  logic             ready,
   input  logic [7:0]       data,
   input  logic             overflow,
   output logic             nextdata_n,
   output logic             key_event,
   output logic             key_break,
   output logic             key_ext,
   output logic [7:0]       key_code,
   output logic             key_down,
   output logic [7:0]       held_code,
   output logic             held_ext,
   output logic [CNT_W-1:0] press_count,
   output logic             ovf_flag
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_POP    = 2'd1,
      S_SETTLE = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic       start_pop;
   logic       decode_en;
   logic [7:0] byte_q;
   logic       ext_pend;
   logic       brk_pend;
   logic       is_e0;
   logic       is_f0;
   logic       matches_held;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start_pop = 1'b0;
      decode_en = 1'b0;
      case (state)
         S_IDLE: begin
            if (en && ready) begin
               start_pop = 1'b1;
               state_nxt = S_POP;
            end
         end
         S_POP: begin
            decode_en = 1'b1;
            state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign is_e0 = (byte_q == 8'hE0);
   assign is_f0 = (byte_q == 8'hF0);
   // A repeat or a release only refers to the held key while one is held.
   assign matches_held = key_down && (byte_q == held_code) && (ext_pend == held_ext);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         nextdata_n  <= 1'b1;
         byte_q      <= 8'h00;
         ext_pend    <= 1'b0;
         brk_pend    <= 1'b0;
         key_event   <= 1'b0;
         key_break   <= 1'b0;
         key_ext     <= 1'b0;
         key_code    <= 8'h00;
         key_down    <= 1'b0;
         held_code   <= 8'h00;
         held_ext    <= 1'b0;
         press_count <= '0;
         ovf_flag    <= 1'b0;
      end else begin
         key_event <= 1'b0;
         if (overflow) begin
            ovf_flag <= 1'b1;
         end
         if (start_pop) begin
            byte_q     <= data;
            nextdata_n <= 1'b0;
         end
         if (decode_en) begin
            nextdata_n <= 1'b1;
            if (is_e0) begin
               ext_pend <= 1'b1;
            end else if (is_f0) begin
               brk_pend <= 1'b1;
            end else begin
               key_event <= 1'b1;
               key_code  <= byte_q;
               key_ext   <= ext_pend;
               key_break <= brk_pend;
               ext_pend  <= 1'b0;
               brk_pend  <= 1'b0;
               if (!brk_pend) begin
                  if (!matches_held) begin
                     key_down    <= 1'b1;
                     held_code   <= byte_q;
                     held_ext    <= ext_pend;
                     press_count <= press_count + 1'b1;
                  end
               end else if (matches_held) begin
                  key_down <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
module tb_ps2_key_ctrl;

   localparam int CNT_W = 8;

   logic             clk;
   logic             clrn;
   logic             en;
   logic             ready;
   logic [7:0]       data;
   logic             overflow;
   logic             nextdata_n;
   logic             key_event;
   logic             key_break;
   logic             key_ext;
   logic [7:0]       key_code;
   logic             key_down;
   logic [7:0]       held_code;
   logic             held_ext;
   logic [CNT_W-1:0] press_count;
   logic             ovf_flag;

   ps2_key_ctrl #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .clrn        (clrn),
      .en          (en),
      .ready       (ready),
      .data        (data),
      .overflow    (overflow),
      .nextdata_n  (nextdata_n),
      .key_event   (key_event),
      .key_break   (key_break),
      .key_ext     (key_ext),
      .key_code    (key_code),
      .key_down    (key_down),
      .held_code   (held_code),
      .held_ext    (held_ext),
      .press_count (press_count),
      .ovf_flag    (ovf_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int n_events = 0;
   int n_pops = 0;

   logic [7:0] q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic refresh();
      ready = (q.size() != 0);
      data  = (q.size() != 0) ? q[0] : 8'h00;
   endtask

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      refresh();
   endtask

   // Reference model: byte-level timing (one pop per three cycles, event two
   // cycles after the sampled ready) plus key tracking by {ext,code} identity.
   int         m_phase;
   logic [7:0] m_byte;
   logic       m_ext_p, m_brk_p;
   logic       e_ndn, e_event, e_brk, e_ext, e_down, e_held_ext, e_ovf;
   logic [7:0] e_code, e_held_code;
   int         e_cnt;

   task automatic model_decode(input logic [7:0] b);
      if (b == 8'hE0) m_ext_p = 1'b1;
      else if (b == 8'hF0) m_brk_p = 1'b1;
      else begin
         e_event = 1'b1;
         e_code  = b;
         e_ext   = m_ext_p;
         e_brk   = m_brk_p;
         if (!m_brk_p) begin
            if (!e_down || {m_ext_p, b} != {e_held_ext, e_held_code}) begin
               e_down      = 1'b1;
               e_held_code = b;
               e_held_ext  = m_ext_p;
               e_cnt       = (e_cnt + 1) % (1 << CNT_W);
            end
         end else if (e_down && {m_ext_p, b} == {e_held_ext, e_held_code}) begin
            e_down = 1'b0;
         end
         m_ext_p = 1'b0;
         m_brk_p = 1'b0;
      end
   endtask

   always @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         m_phase = 0; m_byte = 8'h00; m_ext_p = 0; m_brk_p = 0;
         e_ndn = 1; e_event = 0; e_brk = 0; e_ext = 0; e_down = 0;
         e_held_ext = 0; e_ovf = 0; e_code = 8'h00; e_held_code = 8'h00; e_cnt = 0;
      end else begin
         e_event = 1'b0;
         if (overflow) e_ovf = 1'b1;
         if (m_phase == 0) begin
            if (en && ready) begin
               m_byte  = data;
               e_ndn   = 1'b0;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            e_ndn   = 1'b1;
            model_decode(m_byte);
            m_phase = 2;
         end else begin
            m_phase = 0;
         end
      end
   end

   // Compare every cycle, then act as the receiver FIFO for the pop strobe.
   always @(negedge clk) begin
      chk("nextdata_n", nextdata_n, e_ndn);
      chk("key_event", key_event, e_event);
      chk("key_break", key_break, e_brk);
      chk("key_ext", key_ext, e_ext);
      chk("key_code", key_code, e_code);
      chk("key_down", key_down, e_down);
      chk("held_code", held_code, e_held_code);
      chk("held_ext", held_ext, e_held_ext);
      chk("press_count", press_count, e_cnt[CNT_W-1:0]);
      chk("ovf_flag", ovf_flag, e_ovf);
      if (key_event === 1'b1) n_events++;
      if (nextdata_n === 1'b0) begin
         n_pops++;
         if (q.size() != 0) begin
            void'(q.pop_front());
            refresh();
         end
      end
   end

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
      repeat (4) @(negedge clk);
      #1;
   endtask

   int ev0, pop0;

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clrn = 1'b0; en = 1'b0; overflow = 1'b0;
      refresh();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_nextdata_n", nextdata_n, 1);
      chk("rst_key_event", key_event, 0);
      chk("rst_key_code", key_code, 8'h00);
      chk("rst_press_count", press_count, 0);
      chk("rst_ovf_flag", ovf_flag, 0);
      clrn = 1'b1;

      // single make with cycle-exact timing
      @(negedge clk);
      en = 1'b1;
      push(8'h1C);
      @(negedge clk); #1;
      chk("t1_pop_low", nextdata_n, 0);
      @(negedge clk); #1;
      chk("t1_event", key_event, 1);
      chk("t1_code", key_code, 8'h1C);
      chk("t1_break", key_break, 0);
      chk("t1_down", key_down, 1);
      chk("t1_count", press_count, 1);
      chk("t1_model_cnt", e_cnt, 1);
      @(negedge clk); #1;
      chk("t1_pulse_end", key_event, 0);
      drain();

      // typematic repeats then release
      ev0 = n_events;
      push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
      drain();
      chk("t2_events", n_events - ev0, 4);
      chk("t2_count", press_count, 1);
      chk("t2_down", key_down, 0);
      chk("t2_break", key_break, 1);

      // extended press and release
      ev0 = n_events; pop0 = n_pops;
      push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
      drain();
      chk("t3_events", n_events - ev0, 2);
      chk("t3_pops", n_pops - pop0, 5);
      chk("t3_code", key_code, 8'h75);
      chk("t3_ext", key_ext, 1);
      chk("t3_break", key_break, 1);
      chk("t3_held_ext", held_ext, 1);
      chk("t3_count", press_count, 2);

      // roll-over: hold 1C, press 32, release 1C
      push(8'h1C); push(8'h32); push(8'hF0); push(8'h1C);
      drain();
      chk("t4_held_code", held_code, 8'h32);
      chk("t4_held_ext", held_ext, 0);
      chk("t4_down", key_down, 1);
      chk("t4_count", press_count, 4);
      chk("t4_model_cnt", e_cnt, 4);

      // en low blocks pops; overflow is sticky
      en = 1'b0;
      ev0 = n_events; pop0 = n_pops;
      push(8'h1C);
      repeat (10) @(negedge clk);
      #1;
      chk("t5_no_pop", n_pops - pop0, 0);
      chk("t5_no_event", n_events - ev0, 0);
      chk("t5_ndn_high", nextdata_n, 1);
      overflow = 1'b1;
      @(negedge clk);
      overflow = 1'b0;
      #1;
      chk("t5_ovf_set", ovf_flag, 1);
      en = 1'b1;
      drain();
      chk("t5_ovf_sticky", ovf_flag, 1);
      chk("t5_count", press_count, 5);
      @(negedge clk); #1;
      clrn = 1'b0;
      #1;
      chk("t5_ovf_cleared", ovf_flag, 0);
      chk("t5_count_cleared", press_count, 0);
      @(negedge clk); #1;
      clrn = 1'b1;

      // counter wrap: 255 make/break pairs then one more press
      for (int i = 0; i < 255; i++) begin
         logic [7:0] c;
         c = 8'(i % 200 + 1);
         if (i >= 200) push(8'hE0);
         push(c);
         if (i >= 200) push(8'hE0);
         push(8'hF0);
         push(c);
      end
      drain();
      chk("t6_count_ff", press_count, 8'hFF);
      chk("t6_down", key_down, 0);
      push(8'h1C);
      drain();
      chk("t6_wrap", press_count, 8'h00);
      chk("t6_down_after", key_down, 1);

      // reset in the middle of a pop
      @(negedge clk);
      push(8'h2A);
      @(posedge clk);
      #2;
      chk("t7_in_pop", nextdata_n, 0);
      clrn = 1'b0;
      #1;
      chk("t7_ndn_reset", nextdata_n, 1);
      chk("t7_down_reset", key_down, 0);
      chk("t7_code_reset", key_code, 8'h00);
      @(negedge clk); #1;
      clrn = 1'b1;
      drain();
      chk("t7_code_after", key_code, 8'h2A);
      chk("t7_count_after", press_count, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
